// File: rtl/or_sweep_pkg.sv
// Shared types and helpers for the gate sweeper.
// State encoding, hold-counter width helper, and the reference gate function.
// The reference function is isolated so an AND/XOR sweeper can swap it.
package or_sweep_pkg;

    localparam int MAX_N_IN = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    // The counter is loaded with HOLD-2, so clog2(HOLD) bits always suffice;
    // never go below one bit.
    function automatic int hold_cnt_w(input int hold);
        return (hold <= 2) ? 1 : $clog2(hold);
    endfunction

    // Reference response of the gate under test. Callers zero-extend the
    // vector, which leaves a reduction-OR unaffected.
    function automatic logic expected_y(input logic [MAX_N_IN-1:0] vec);
        return |vec;
    endfunction

endpackage

// File: rtl/sweep_hold_counter.sv
// Hold-window timer: loadable down-counter that strobes on the last DRIVE cycle.
// Ports: load (restart window), en (count while driving), last_cycle (strobe).
// Loaded with HOLD-2 so DRIVE lasts HOLD-1 cycles and SAMPLE makes it HOLD.
module sweep_hold_counter #(
    parameter int HOLD = 4,
    parameter int W    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic last_cycle
);

    localparam logic [W-1:0] LOAD_VAL = W'(HOLD - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last_cycle = en && (cnt == '0);

endmodule

// File: rtl/or_gate_sweeper.sv
// Exhaustive stimulus/response checker for an N_IN-input OR gate.
// Ports: start kicks a sweep; vec_out drives the gate, y_in is its output;
// busy/done/pass/err_count/first_fail_* report the result (held until restart).
module or_gate_sweeper
    import or_sweep_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int HW = hold_cnt_w(HOLD);
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(1) << N_IN;
    localparam logic [N_IN-1:0] VEC_ONES = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

    sweep_state_t state;

    logic            start_ok;
    logic            cnt_load;
    logic            last_cycle;
    logic            mismatch;
    logic [N_IN:0]   err_next;
    logic [MAX_N_IN-1:0] vec_ext;

    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    // Reloading on every SAMPLE is harmless on the final vector.
    assign cnt_load = start_ok || (state == ST_SAMPLE);

    sweep_hold_counter #(
        .HOLD (HOLD),
        .W    (HW)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .en         (state == ST_DRIVE),
        .last_cycle (last_cycle)
    );

    always_comb begin
        vec_ext = '0;
        vec_ext[N_IN-1:0] = vec_out;
    end

    assign mismatch = (y_in != expected_y(vec_ext));

    // Saturate; with one compare per vector the ceiling is never exceeded
    // anyway, but this keeps the count monotonic under any sequencing.
    always_comb begin
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + ERR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state            <= ST_DRIVE;
                        vec_out          <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (last_cycle) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= vec_out;
                        first_fail_valid <= 1'b1;
                    end
                    if (vec_out == VEC_ONES) begin
                        state   <= ST_DONE;
                        vec_out <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next == '0);
                    end else begin
                        state   <= ST_DRIVE;
                        vec_out <= vec_out + VEC_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or_gate_sweeper.sv
// Bench for or_gate_sweeper: two instances (N_IN=2/HOLD=4, N_IN=3/HOLD=2)
// driving a behavioural gate whose fault mode is selectable per sweep.
// Expected results are queued at start and compared when done rises.
module tb_or_gate_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic st [2];
    int   mode [2];

    logic [1:0] vec0;
    logic [2:0] vec1;
    logic       y0, y1;
    logic       busy0, done0, pass0, ffvl0;
    logic       busy1, done1, pass1, ffvl1;
    logic [2:0] err0;
    logic [3:0] err1;
    logic [1:0] ffv0;
    logic [2:0] ffv1;

    // 0: good OR, 1: stuck-at-0, 2: AND gate, 3: stuck-at-1
    function automatic logic gate_model(input int m, input int v, input int n);
        case (m)
            0:       return v != 0;
            1:       return 1'b0;
            2:       return v == ((1 << n) - 1);
            default: return 1'b1;
        endcase
    endfunction

    always_comb y0 = gate_model(mode[0], int'(vec0), 2);
    always_comb y1 = gate_model(mode[1], int'(vec1), 3);

    or_gate_sweeper #(.N_IN(2), .HOLD(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .vec_out(vec0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvl0)
    );

    or_gate_sweeper #(.N_IN(3), .HOLD(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .vec_out(vec1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffvl1)
    );

    // Uniform views of both instances for the shared sweep task.
    logic [7:0] vo [2];
    logic [8:0] ec [2];
    logic [7:0] fv [2];
    logic       bz [2], dn [2], ps [2], fvl [2];
    always_comb begin
        vo[0] = {6'd0, vec0};  vo[1] = {5'd0, vec1};
        ec[0] = {6'd0, err0};  ec[1] = {5'd0, err1};
        fv[0] = {6'd0, ffv0};  fv[1] = {5'd0, ffv1};
        bz[0] = busy0; bz[1] = busy1;
        dn[0] = done0; dn[1] = done1;
        ps[0] = pass0; ps[1] = pass1;
        fvl[0] = ffvl0; fvl[1] = ffvl1;
    end

    typedef struct {
        int err;
        int ffv;
        bit ffvalid;
        bit pass_;
    } exp_t;

    exp_t sb [$];

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sweep(input int s, input int n, input int hold,
                         input int m, input int pulse_at);
        exp_t e;
        exp_t got;
        int   last;
        last = (1 << n) * hold;
        e.err = 0; e.ffv = 0; e.ffvalid = 1'b0;
        for (int v = 0; v < (1 << n); v++) begin
            if (gate_model(m, v, n) != (v != 0)) begin
                e.err++;
                if (!e.ffvalid) begin
                    e.ffv = v;
                    e.ffvalid = 1'b1;
                end
            end
        end
        e.pass_ = (e.err == 0);

        @(negedge clk);
        mode[s] = m;
        st[s]   = 1'b1;
        sb.push_back(e);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            st[s] = (c == pulse_at);
            chk($sformatf("s%0d_busy_c%0d", s, c), 32'(bz[s]), 32'd1);
            chk($sformatf("s%0d_vec_c%0d", s, c), 32'(vo[s]), 32'((c - 1) / hold));
            if (c == 1) begin
                chk($sformatf("s%0d_done_clr", s), 32'(dn[s]), 32'd0);
                chk($sformatf("s%0d_err_clr", s), 32'(ec[s]), 32'd0);
                chk($sformatf("s%0d_ffvl_clr", s), 32'(fvl[s]), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("s%0d_done_end", s), 32'(dn[s]), 32'd1);
        chk($sformatf("s%0d_busy_end", s), 32'(bz[s]), 32'd0);
        chk($sformatf("s%0d_vec_end", s), 32'(vo[s]), 32'd0);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk($sformatf("s%0d_err", s), 32'(ec[s]), 32'(got.err));
            chk($sformatf("s%0d_pass", s), 32'(ps[s]), 32'(got.pass_));
            chk($sformatf("s%0d_ffvl", s), 32'(fvl[s]), 32'(got.ffvalid));
            if (got.ffvalid) chk($sformatf("s%0d_ffv", s), 32'(fv[s]), 32'(got.ffv));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"},  32'(vec0),  32'd0);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_pass"}, 32'(pass0), 32'd0);
        chk({tag, "_err"},  32'(err0),  32'd0);
        chk({tag, "_ffv"},  32'(ffv0),  32'd0);
        chk({tag, "_ffvl"}, 32'(ffvl0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;
        mode[0] = 0;  mode[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Abort mid-DRIVE at vector 2'b10 (cycle 10) with asynchronous reset.
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_vec", 32'(vec0), 32'd2);
        chk("pre_rst_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        sweep(0, 2, 4, 0, 0);   // good OR gate
        sweep(0, 2, 4, 1, 0);   // stuck-at-0
        sweep(0, 2, 4, 2, 0);   // AND substituted
        sweep(0, 2, 4, 0, 6);   // start pulsed while busy
        sweep(0, 2, 4, 0, 0);   // restart from DONE, same timing
        sweep(1, 3, 2, 3, 0);   // N_IN=3, HOLD=2, stuck-at-1

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/or_gate_sweeper.md
# or_gate_sweeper

Self-checking stimulus and response stage for the OR-gate cell. The sweeper sits directly upstream of the gate, driving its input vector through every combination. It also sits directly downstream, sampling the gate output against the expected OR. It counts mismatches, captures the first failing vector, and reports pass/fail. This lets the gate be exercised in hardware (FPGA bring-up or a self-checking top) without the waveform bench.

## Interface
Parameters:
- N_IN, default 2: gate input width; legal range 2..8.
- HOLD, default 4: cycles each vector is held; legal range 2..255.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a sweep; sampled only in IDLE or DONE.
- vec_out, output, N_IN: drives the gate inputs (bit 0 → A, bit 1 → B for N_IN=2).
- y_in, input, 1: gate output Y.
- busy, output, 1: sweep in progress.
- done, output, 1: sweep complete; level, held until next start or reset.
- pass, output, 1: 1 when done and err_count == 0.
- err_count, output, N_IN+1: number of mismatching vectors.
- first_fail_vec, output, N_IN: first vector that mismatched.
- first_fail_valid, output, 1: first_fail_vec is meaningful.

## Operation
- FSM states:
  - IDLE: start=1 → DRIVE, with vector=0, hold count=0, counters cleared.
  - DRIVE: hold count increments each cycle. When hold count = HOLD-1 → SAMPLE.
  - SAMPLE: one cycle. Compare y_in with expected (|vec_out). Update counters.
    - vec_out all-ones → DONE.
    - Otherwise vector+1 → DRIVE.
  - DONE: start=1 → same as IDLE start.
- vec_out is held stable through DRIVE and SAMPLE of its vector. It changes only on the SAMPLE→DRIVE edge.
- Mismatch handling:
  - err_count increments by 1.
  - If first_fail_valid=0: capture vec_out into first_fail_vec and set first_fail_valid.
- err_count never wraps. Its maximum is 2^N_IN, which fits in N_IN+1 bits.
- start while busy is ignored.
- start held high across DONE restarts immediately; counters clear on the restart edge.
- vec_out returns to 0 in IDLE and DONE.

## Timing
- All outputs reset asynchronously to 0 while rst_n=0: vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid.
- Reset mid-sweep aborts the sweep. No partial results are retained.
- Start edge = cycle 0:
  - busy=1 from cycle 1.
  - Vector k is driven for cycles 1+k·HOLD through (k+1)·HOLD.
  - The comparison uses y_in present during the SAMPLE cycle, i.e. the last cycle of the hold window. This gives the gate HOLD-1 cycles to settle.
- Sweep end:
  - done=1 and busy=0 from cycle 1 + 2^N_IN·HOLD.
  - pass is valid in that same cycle.
  - For N_IN=2 and HOLD=4, done rises at cycle 17.
- The final vector's compare result is visible in err_count in the same cycle that done rises.
- Restart from DONE:
  - done, pass, err_count and first_fail_* clear on the cycle after the start edge.
  - busy=1 in that same cycle.

## Structure
- Shared package or_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - a clog2-based helper for the hold-counter width;
  - a function expected_y(vec) that returns the reduction-OR. The expected function stays swappable for later AND/XOR sweepers.
- One natural sub-module, sweep_hold_counter:
  - loadable down-counter of width clog2(HOLD);
  - produces a one-cycle last_cycle strobe;
  - is cleared by the FSM.
- Top-level: FSM, vector register, compare and result registers.

## Test plan
- Reset: assert rst_n=0 mid-DRIVE at vector 2'b10 → all outputs 0 immediately. After release, start → vec_out=00 at cycle 1.
- Good OR gate, N_IN=2, HOLD=4 → vec_out sequence 00, 01, 10, 11, each 4 cycles. Result: done at cycle 17, err_count=0, pass=1, first_fail_valid=0.
- y_in stuck at 0 → err_count=3, first_fail_vec=01, pass=0.
- AND gate substituted for OR → mismatches at 01 and 10. Result: err_count=2, first_fail_vec=01, first_fail_valid=1.
- start pulsed at cycle 6 while busy → no effect, done still at cycle 17. A second start in DONE clears results and sweeps again with identical timing.
- N_IN=3, HOLD=2, y_in stuck at 1 → err_count=1 (vector 000), first_fail_vec=000. done at cycle 17.
